uart_rx_ctrl: RTL and testbench

- Receive-side sequencer for the UART RX datapath.
- Detects the start bit on an oversampled serial line and majority-votes each bit.
- Drives the deserializer and parity checker with one-cycle enables, checks the stop bit, and reports one status pulse per frame.
- Sits between the upstream RXD synchronizer and the deserializer/parity-check datapath inside UART_RX_TOP.

---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/uart_rx_sampler.sv | 36 +++
 rtl/uart_rx_ctrl.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive sequencer.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int MIN_PRESCALE   = 8;
    localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-point majority vote around the middle of each bit period.
// The vote is registered after the third sample, so it is valid from edge P/2+2.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RXD,
    input  logic [PRESCALE_W-1:0] E,
    input  logic [PRESCALE_W-1:0] P,
    output logic                  SAMPLED_BIT
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] mid;
    logic                  s0;
    logic                  s1;

    assign mid = P >> 1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s0          <= 1'b0;
            s1          <= 1'b0;
            SAMPLED_BIT <= 1'b0;
        end else begin
            if (E == mid - ONE) s0 <= RXD;
            if (E == mid) s1 <= RXD;
            if (E == mid + ONE) SAMPLED_BIT <= (s0 & s1) | (s0 & RXD) | (s1 & RXD);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, per-bit strobes for the deserializer
// and parity checker, stop-bit check and one status pulse per frame.
//
// state  | meaning
// IDLE   | line idle; RXD=0 starts a frame and latches PRESCALE/PARITY_EN
// START  | start bit; a high vote at the decision edge means a glitch
// DATA   | data bits, one DESER_EN strobe per bit at the decision edge
// PARITY | parity bit, one PAR_CHK_EN strobe, parity result captured
// STOP   | stop bit; at the decision edge return to IDLE and pulse status
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PRESCALE_W = 6
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          RXD,
    input  logic                          PARITY_EN,
    input  logic [PRESCALE_W-1:0]         PRESCALE,
    input  logic                          PAR_ERR,
    output logic                          SAMPLED_BIT,
    output logic                          DESER_EN,
    output logic [$clog2(DATA_WIDTH)-1:0] BIT_IDX,
    output logic                          PAR_CHK_EN,
    output logic                          VALID_RX,
    output logic                          PARITY_ERROR,
    output logic                          STOP_ERROR,
    output logic                          BUSY
);

    localparam int                    CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [PRESCALE_W-1:0] P_ONE    = PRESCALE_W'(1);
    localparam logic [PRESCALE_W-1:0] P_TWO    = PRESCALE_W'(2);
    localparam logic [PRESCALE_W-1:0] P_MIN    = PRESCALE_W'(MIN_PRESCALE);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_WIDTH);

    rx_state_t             state;
    rx_state_t             state_n;
    logic [PRESCALE_W-1:0] e_cnt;
    logic [PRESCALE_W-1:0] e_n;
    logic [PRESCALE_W-1:0] e_wrap;
    logic [PRESCALE_W-1:0] p_q;
    logic [PRESCALE_W-1:0] p_even;
    logic [PRESCALE_W-1:0] p_new;
    logic [PRESCALE_W-1:0] half;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      bit_n;
    logic                  par_en_q;
    logic                  par_err_q;
    logic                  capture;
    logic                  par_cap;
    logic                  stop_done;
    logic                  at_d;
    logic                  at_end;

    // bit 0 dropped so the half-period is exact; short periods clamp up
    assign p_even = PRESCALE & ~P_ONE;
    assign p_new  = (p_even < P_MIN) ? P_MIN : p_even;

    assign half    = p_q >> 1;
    assign at_d    = (e_cnt == half + P_TWO);
    assign at_end  = (e_cnt == p_q - P_ONE);
    assign e_wrap  = at_end ? '0 : e_cnt + P_ONE;
    assign BUSY    = (state != IDLE);
    assign BIT_IDX = bit_cnt[$clog2(DATA_WIDTH)-1:0];

    uart_rx_sampler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_sampler (
        .CLK        (CLK),
        .RST        (RST),
        .RXD        (RXD),
        .E          (e_cnt),
        .P          (p_q),
        .SAMPLED_BIT(SAMPLED_BIT)
    );

    always_comb begin
        state_n    = state;
        e_n        = e_wrap;
        bit_n      = bit_cnt;
        DESER_EN   = 1'b0;
        PAR_CHK_EN = 1'b0;
        capture    = 1'b0;
        par_cap    = 1'b0;
        stop_done  = 1'b0;
        case (state)
            IDLE: begin
                e_n   = '0;
                bit_n = '0;
                if (!RXD) begin
                    state_n = START;
                    e_n     = P_ONE;
                    capture = 1'b1;
                end
            end
            START: begin
                if (at_d && SAMPLED_BIT) begin
                    state_n = IDLE;
                    e_n     = '0;
                end else if (at_end) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (at_d) begin
                    DESER_EN = 1'b1;
                    bit_n    = bit_cnt + CNT_ONE;
                end
                if (at_end && bit_cnt == CNT_LAST) state_n = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (at_d) begin
                    PAR_CHK_EN = 1'b1;
                    par_cap    = 1'b1;
                end
                if (at_end) state_n = STOP;
            end
            STOP: begin
                // leaving at the decision edge resynchronises early for back-to-back frames
                if (at_d) begin
                    stop_done = 1'b1;
                    state_n   = IDLE;
                    e_n       = '0;
                end
            end
            default: begin
                state_n = IDLE;
                e_n     = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            e_cnt        <= '0;
            bit_cnt      <= '0;
            p_q          <= P_MIN;
            par_en_q     <= 1'b0;
            par_err_q    <= 1'b0;
            VALID_RX     <= 1'b0;
            PARITY_ERROR <= 1'b0;
            STOP_ERROR   <= 1'b0;
        end else begin
            state        <= state_n;
            e_cnt        <= e_n;
            bit_cnt      <= bit_n;
            VALID_RX     <= stop_done & SAMPLED_BIT & ~par_err_q;
            PARITY_ERROR <= stop_done & par_err_q;
            STOP_ERROR   <= stop_done & ~SAMPLED_BIT;
            if (capture) begin
                p_q       <= p_new;
                par_en_q  <= PARITY_EN;
                par_err_q <= 1'b0;
            end else if (par_cap) begin
                par_err_q <= PAR_ERR;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: frames are scheduled into a per-cycle expectation table
// computed from frame timing arithmetic and compared against the DUT every cycle.
module tb_uart_rx_ctrl;

    localparam int DW = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RXD = 1'b1;
    logic       PARITY_EN = 1'b0;
    logic [5:0] PRESCALE = 6'd8;
    logic       PAR_ERR = 1'b0;
    logic       SAMPLED_BIT;
    logic       DESER_EN;
    logic [2:0] BIT_IDX;
    logic       PAR_CHK_EN;
    logic       VALID_RX;
    logic       PARITY_ERROR;
    logic       STOP_ERROR;
    logic       BUSY;

    uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(6)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RXD         (RXD),
        .PARITY_EN   (PARITY_EN),
        .PRESCALE    (PRESCALE),
        .PAR_ERR     (PAR_ERR),
        .SAMPLED_BIT (SAMPLED_BIT),
        .DESER_EN    (DESER_EN),
        .BIT_IDX     (BIT_IDX),
        .PAR_CHK_EN  (PAR_CHK_EN),
        .VALID_RX    (VALID_RX),
        .PARITY_ERROR(PARITY_ERROR),
        .STOP_ERROR  (STOP_ERROR),
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       busy;
        logic       deser;
        logic [7:0] idx;
        logic       dbit;
        logic       par;
        logic       pbit;
        logic       stat_v;
        logic [2:0] stat;   // {valid, parity_error, stop_error}
    } exp_t;

    exp_t       exp_q[int];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    bit         chk_en = 1'b0;
    bit         q_bits[$];
    int         q_pulse[$];
    logic [2:0] q_stat[$];
    int         n_par = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t get_exp(input int c);
        if (exp_q.exists(c)) return exp_q[c];
        return '0;
    endfunction

    function automatic void purge(input int from);
        int keys[$];
        foreach (exp_q[c]) if (c >= from) keys.push_back(c);
        foreach (keys[i]) exp_q.delete(keys[i]);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        q_bits.delete();
        q_pulse.delete();
        q_stat.delete();
        n_par = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            RXD       = 1'b1;
            PRESCALE  = 6'($urandom_range(0, 63));
            PARITY_EN = 1'($urandom_range(0, 1));
            PAR_ERR   = 1'($urandom_range(0, 1));
        end
    endtask

    // Low pulse of len cycles, short enough that the vote sees the line high.
    task automatic glitch(input int p_raw, input int len, output int t0);
        int   p, d;
        exp_t e;
        p = p_raw & ~1;
        if (p < 8) p = 8;
        d = p / 2 + 2;
        tick();
        t0 = cyc;
        for (int c = t0 + 1; c <= t0 + d; c++) begin
            e = get_exp(c); e.busy = 1'b1; exp_q[c] = e;
        end
        for (int k = 0; k <= d; k++) begin
            if (k > 0) tick();
            RXD       = (k < len) ? 1'b0 : 1'b1;
            PRESCALE  = (k == 0) ? 6'(p_raw) : 6'($urandom_range(0, 63));
            PARITY_EN = 1'($urandom_range(0, 1));
            PAR_ERR   = 1'($urandom_range(0, 1));
        end
    endtask

    // Drives one frame from its detection cycle through the stop-bit decision edge.
    task automatic frame(input int p_raw, input bit par_en, input logic [7:0] data,
                         input bit pbit, input bit par_err_v, input bit stop_v,
                         input bit use_flip, input int rst_at, output int t0);
        int   p, d, n, tp, last, pe;
        int   flip_e[16];
        exp_t e;
        p = p_raw & ~1;
        if (p < 8) p = 8;
        d    = p / 2 + 2;
        n    = 1 + DW + int'(par_en);
        pe   = int'(par_en & par_err_v);
        last = n * p + d;
        tick();
        t0 = cyc;
        tp = t0 + n * p + p / 2 + 3;
        for (int j = 0; j < 16; j++)
            flip_e[j] = (use_flip && $urandom_range(0, 1) == 1) ? (p / 2 - 1 + int'($urandom_range(0, 2))) : -1;
        for (int c = t0 + 1; c < tp; c++) begin
            e = get_exp(c); e.busy = 1'b1; exp_q[c] = e;
        end
        for (int i = 0; i < DW; i++) begin
            int c;
            c = t0 + (1 + i) * p + d;
            e = get_exp(c); e.deser = 1'b1; e.idx = 8'(i); e.dbit = data[i]; exp_q[c] = e;
        end
        if (par_en) begin
            int c;
            c = t0 + (1 + DW) * p + d;
            e = get_exp(c); e.par = 1'b1; e.pbit = pbit; exp_q[c] = e;
        end
        e = get_exp(tp);
        e.stat_v = 1'b1;
        e.stat   = {(pe == 0) && stop_v, pe == 1, !stop_v};
        exp_q[tp] = e;
        for (int k = 0; k <= last; k++) begin
            int j, ph;
            bit bv;
            if (k > 0) tick();
            j  = k / p;
            ph = k % p;
            if (j == 0) bv = 1'b0;
            else if (j <= DW) bv = data[j-1];
            else if (j == n) bv = stop_v;
            else bv = pbit;
            RXD     = bv ^ (ph == flip_e[j]);
            PAR_ERR = (par_en && k == (1 + DW) * p + d) ? par_err_v : 1'($urandom_range(0, 1));
            if (k == 0) begin
                PRESCALE  = 6'(p_raw);
                PARITY_EN = par_en;
            end else begin
                PRESCALE  = 6'($urandom_range(0, 63));
                PARITY_EN = 1'($urandom_range(0, 1));
            end
            if (k == rst_at) begin
                RST = 1'b1;
                purge(t0 + k + 1);
                tick();
                chk("reset_outputs_zero",
                    {SAMPLED_BIT, DESER_EN, BIT_IDX, PAR_CHK_EN, VALID_RX, PARITY_ERROR, STOP_ERROR, BUSY}, 0);
                RST = 1'b0;
                RXD = 1'b1;
                break;
            end
        end
    endtask

    always @(negedge CLK) begin : cmp
        exp_t e;
        if (chk_en) begin
            e = get_exp(cyc);
            chk("busy", BUSY, e.busy);
            chk("deser_en", DESER_EN, e.deser);
            chk("par_chk_en", PAR_CHK_EN, e.par);
            chk("status", {VALID_RX, PARITY_ERROR, STOP_ERROR}, e.stat_v ? e.stat : 3'b000);
            if (e.deser) begin
                chk("bit_idx", BIT_IDX, e.idx);
                chk("data_sample", SAMPLED_BIT, e.dbit);
            end
            if (e.par) chk("parity_sample", SAMPLED_BIT, e.pbit);
            if (DESER_EN === 1'b1) q_bits.push_back(SAMPLED_BIT);
            if (PAR_CHK_EN === 1'b1) n_par++;
            if ((VALID_RX | PARITY_ERROR | STOP_ERROR) === 1'b1) begin
                q_pulse.push_back(cyc);
                q_stat.push_back({VALID_RX, PARITY_ERROR, STOP_ERROR});
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t0, t1;
        logic [7:0] b;
        repeat (3) tick();
        chk("reset_state",
            {SAMPLED_BIT, DESER_EN, BIT_IDX, PAR_CHK_EN, VALID_RX, PARITY_ERROR, STOP_ERROR, BUSY}, 0);
        RST    = 1'b0;
        chk_en = 1'b1;
        idle(4);

        // 0x6F, P=8, parity on with correct even parity
        clr();
        frame(8, 1'b1, 8'h6F, 1'b0, 1'b0, 1'b1, 1'b0, -1, t0);
        idle(3);
        chk("t1_deser_count", q_bits.size(), 8);
        b = '0;
        for (int i = 0; i < 8; i++) if (i < q_bits.size()) b[i] = q_bits[i];
        chk("t1_sampled_bits", b, 8'h6F);
        chk("t1_par_count", n_par, 1);
        chk("t1_latency", (q_pulse.size() > 0) ? q_pulse[0] - t0 : -1, 87);
        chk("t1_status", (q_stat.size() > 0) ? q_stat[0] : 3'b000, 3'b100);

        // 0xCC, P=16, parity off
        clr();
        frame(16, 1'b0, 8'hCC, 1'b0, 1'b1, 1'b1, 1'b1, -1, t0);
        idle(2);
        chk("t2_busy_after_pulse", BUSY, 0);
        idle(2);
        chk("t2_latency", (q_pulse.size() > 0) ? q_pulse[0] - t0 : -1, 155);
        chk("t2_par_count", n_par, 0);

        // stop bit low and parity error together
        clr();
        frame(8, 1'b1, 8'h3A, 1'b1, 1'b1, 1'b0, 1'b0, -1, t0);
        idle(3);
        chk("t3_pulse_count", q_pulse.size(), 1);
        chk("t3_status", (q_stat.size() > 0) ? q_stat[0] : 3'b000, 3'b011);

        // three-cycle low glitch
        clr();
        glitch(8, 3, t0);
        idle(1);
        chk("t4_busy_cycle7", BUSY, 0);
        idle(3);
        chk("t4_deser_count", q_bits.size(), 0);
        chk("t4_pulse_count", q_pulse.size(), 0);

        // back-to-back: second start in the first pulse cycle
        clr();
        frame(8, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, -1, t0);
        frame(8, 1'b1, 8'h5C, 1'b0, 1'b0, 1'b1, 1'b1, -1, t1);
        idle(3);
        chk("t5_pulse_count", q_pulse.size(), 2);
        chk("t5_second_start", (q_pulse.size() > 0) ? q_pulse[0] : -1, t1);
        chk("t5_spacing", (q_pulse.size() > 1) ? q_pulse[1] - q_pulse[0] : -1, 87);
        chk("t5_status", (q_stat.size() > 1) ? {q_stat[0], q_stat[1]} : 6'd0, 6'b100100);

        // reset during data bit 4, then PRESCALE=5 clamps to 8
        clr();
        frame(8, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 5 * 8 + 3, t0);
        idle(3);
        chk("t6_no_pulse", q_pulse.size(), 0);
        clr();
        frame(5, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, -1, t0);
        idle(3);
        chk("t6_clamped_latency", (q_pulse.size() > 0) ? q_pulse[0] - t0 : -1, 87);

        // randomized frames, glitches, resets and gaps
        for (int it = 0; it < 25; it++) begin
            int sel, gap;
            sel = int'($urandom_range(0, 99));
            if (sel < 15) begin
                int praw, pp;
                praw = int'($urandom_range(0, 63));
                pp   = praw & ~1;
                if (pp < 8) pp = 8;
                glitch(praw, int'($urandom_range(1, pp / 2)), t0);
            end else begin
                frame(int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 8'($urandom),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                      (sel >= 90) ? int'($urandom_range(1, 78)) : -1, t0);
            end
            gap = int'($urandom_range(0, 4));
            idle(gap);
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
